// File: rtl/mod_mul_arbiter_if.sv
// Handshake bundle between two requesters, the shared mod_mul arbiter and its result consumer.
// Latency: none, wires only.
// Backpressure: carries the valid/ready pairs; no storage here.
interface mod_mul_arbiter_if #(
    parameter int DATA_W = 23,
    parameter int ID_W   = 1
);
    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [DATA_W-1:0] req0_a_i;
    logic [DATA_W-1:0] req0_b_i;
    logic              req0_sel_i;
    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [DATA_W-1:0] req1_a_i;
    logic [DATA_W-1:0] req1_b_i;
    logic              req1_sel_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [DATA_W-1:0] res_c_o;
    logic [ID_W-1:0]   res_id_o;
    logic              busy_o;

    modport slave (
        input  req0_valid_i, req0_a_i, req0_b_i, req0_sel_i,
        input  req1_valid_i, req1_a_i, req1_b_i, req1_sel_i,
        input  res_ready_i,
        output req0_ready_o, req1_ready_o,
        output res_valid_o, res_c_o, res_id_o, busy_o
    );

    modport master (
        output req0_valid_i, req0_a_i, req0_b_i, req0_sel_i,
        output req1_valid_i, req1_a_i, req1_b_i, req1_sel_i,
        output res_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  res_valid_o, res_c_o, res_id_o, busy_o
    );
endinterface

// File: rtl/mod_mul_arbiter.sv
// Round-robin share of one combinational (a*b) mod q (q=8380417 or 3329) between two requesters.
// Latency: result valid two edges after accept; one result per cycle sustained.
// Backpressure: stalled result holds S2, S2 holds S1, readys drop once S1 is full.
module mod_mul_arbiter #(
    parameter int DATA_W = 23,
    parameter int ID_W   = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mod_mul_arbiter_if.slave   bus
);
    localparam int PW = 2 * DATA_W;
    localparam logic [PW-1:0] Q_DIL = PW'(8380417);
    localparam logic [PW-1:0] Q_KYB = PW'(3329);

    function automatic logic [DATA_W-1:0] mod_mul(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic              sel);
        logic [PW-1:0] p;
        logic [PW-1:0] r;
        p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        r = sel ? (p % Q_KYB) : (p % Q_DIL);
        return r[DATA_W-1:0];
    endfunction

    logic              s1_vld;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic              s1_sel;
    logic [ID_W-1:0]   s1_id;
    logic              res_vld;
    logic [DATA_W-1:0] res_c;
    logic [ID_W-1:0]   res_id;
    logic              last_grant;

    logic              adv2;
    logic              s1_free;
    logic              gnt_vld;
    logic              gnt_id;
    logic [DATA_W-1:0] mm_c;

    assign adv2    = s1_vld & (~res_vld | bus.res_ready_i);
    assign s1_free = ~s1_vld | adv2;
    assign mm_c    = mod_mul(s1_a, s1_b, s1_sel);

    // Contention goes to the requester that did not win last time.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (s1_free) begin
            if (bus.req0_valid_i && bus.req1_valid_i) begin
                gnt_vld = 1'b1;
                gnt_id  = ~last_grant;
            end else if (bus.req0_valid_i) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (bus.req1_valid_i) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign bus.req0_ready_o = gnt_vld & ~gnt_id;
    assign bus.req1_ready_o = gnt_vld &  gnt_id;
    assign bus.res_valid_o  = res_vld;
    assign bus.res_c_o      = res_c;
    assign bus.res_id_o     = res_id;
    assign bus.busy_o       = s1_vld | res_vld;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_vld     <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_sel     <= 1'b0;
            s1_id      <= '0;
            res_vld    <= 1'b0;
            res_c      <= '0;
            res_id     <= '0;
            last_grant <= 1'b1;
        end else begin
            if (adv2) begin
                res_vld <= 1'b1;
                res_c   <= mm_c;
                res_id  <= s1_id;
            end else if (bus.res_ready_i) begin
                res_vld <= 1'b0;
            end

            // A grant implies s1_free, so reload and drain share the same edge.
            if (gnt_vld) begin
                s1_vld     <= 1'b1;
                s1_a       <= gnt_id ? bus.req1_a_i   : bus.req0_a_i;
                s1_b       <= gnt_id ? bus.req1_b_i   : bus.req0_b_i;
                s1_sel     <= gnt_id ? bus.req1_sel_i : bus.req0_sel_i;
                s1_id      <= ID_W'(gnt_id);
                last_grant <= gnt_id;
            end else if (adv2) begin
                s1_vld <= 1'b0;
            end
        end
    end
endmodule
